// File: rtl/gc_arbiter.sv
// gc_arbiter: global counter with single increment port, arbitrated among N_REQ requesters.
// Define GC_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module gc_arbiter #(
  parameter int N_REQ    = 4,
  parameter int GC_WIDTH = 16,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                set_valid,
  input  logic [GC_WIDTH-1:0] set_value,
  output logic [GC_WIDTH-1:0] gc,
  output logic                running,
  output logic [IW-1:0]       grant_idx,
  output logic [31:0]         grant_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [GC_WIDTH-1:0] gc_q;
  logic [IW-1:0]       idx_q;
  logic [31:0]         cnt_q;
  logic [IW-1:0]       win;
  logic                hit;
  logic                grant;

`ifdef GC_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [IW:0]   sum;

  // Scan p, p+1, ... wrapping at N_REQ; first asserted request wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ))
        sum = sum - (IW+1)'(N_REQ);
      if (!hit && req_valid[sum[IW-1:0]]) begin
        hit = 1'b1;
        win = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else if (grant)
      ptr_q <= (win == IW'(N_REQ-1)) ? '0 : win + IW'(1);
  end
`else
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hit && req_valid[i]) begin
        hit = 1'b1;
        win = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (state_q == RUN && !set_valid && hit)
      req_ready[win] = 1'b1;
  end

  assign grant = |req_ready;

  always_comb begin
    state_d = state_q;
    if (set_valid)
      state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gc_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (set_valid) begin
        gc_q  <= set_value;
        cnt_q <= '0;
      end else if (grant) begin
        gc_q  <= gc_q + GC_WIDTH'(1);
        idx_q <= win;
        if (cnt_q != 32'hFFFF_FFFF)
          cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign gc          = gc_q;
  assign running     = (state_q == RUN);
  assign grant_idx   = idx_q;
  assign grant_count = cnt_q;

endmodule

// File: tb/tb_gc_arbiter.sv
// tb_gc_arbiter: vector table, round-robin/priority sequence and randomized
// run against a behavioural model of the global counter arbiter.
module tb_gc_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic          set_valid;
  logic [W-1:0]  set_value;
  logic [W-1:0]  gc;
  logic          running;
  logic [1:0]    grant_idx;
  logic [31:0]   grant_count;

  gc_arbiter #(.N_REQ(N), .GC_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .set_valid(set_valid), .set_value(set_value),
    .gc(gc), .running(running),
    .grant_idx(grant_idx), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  bit          m_run;
  logic [W-1:0] m_gc;
  int          m_ptr;
  int unsigned m_cnt;
  int          m_idx;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rv);
    int p;
`ifdef GC_ARB_RR_EN
    p = m_ptr;
`else
    p = 0;
`endif
    for (int k = 0; k < N; k++)
      if (rv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic [W-1:0] v,
                     input logic [N-1:0] rv);
    int w;
    logic [N-1:0] er;
    rst = r; set_valid = s; set_value = v; req_valid = rv;
    #1;
    w  = pick(rv);
    er = '0;
    if (m_run && !s && w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("ready_without_valid", 32'(req_ready & ~rv), 32'd0);
    @(posedge clk);
    #1;
    if (r) begin
      m_run = 0; m_gc = '0; m_cnt = 0; m_idx = 0; m_ptr = 0;
    end else if (s) begin
      m_run = 1; m_gc = v; m_cnt = 0;
    end else if (er != 0) begin
      m_gc  = m_gc + 1'b1;
      m_idx = w;
      m_ptr = (w + 1) % N;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    chk("gc", 32'(gc), 32'(m_gc));
    chk("running", 32'(running), 32'(m_run));
    chk("grant_count", grant_count, m_cnt);
    chk("grant_idx", 32'(grant_idx), 32'(m_idx));
  endtask

  typedef struct {
    logic         r;
    logic         s;
    logic [W-1:0] v;
    logic [N-1:0] rv;
    logic [N-1:0] e_rdy;
    logic [W-1:0] e_gc;
    logic [31:0]  e_cnt;
    logic         e_run;
  } vec_t;

  vec_t tbl[14];

  initial begin
    rst = 1'b1; set_valid = 1'b0; set_value = '0; req_valid = '0;
    m_run = 0; m_gc = '0; m_ptr = 0; m_cnt = 0; m_idx = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_gc", 32'(gc), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_grant_count", grant_count, 32'd0);
    chk("reset_grant_idx", 32'(grant_idx), 32'd0);

    //         r  s  value     rv       ready    gc_after  cnt run
    tbl[0]  = '{0, 0, 16'd0,    4'b1111, 4'b0000, 16'd0,    0, 0};
    tbl[1]  = '{0, 0, 16'd0,    4'b1111, 4'b0000, 16'd0,    0, 0};
    tbl[2]  = '{0, 1, 16'd100,  4'b0000, 4'b0000, 16'd100,  0, 1};
    tbl[3]  = '{0, 0, 16'd0,    4'b0001, 4'b0001, 16'd101,  1, 1};
    tbl[4]  = '{0, 0, 16'd0,    4'b0001, 4'b0001, 16'd102,  2, 1};
    tbl[5]  = '{0, 0, 16'd0,    4'b0001, 4'b0001, 16'd103,  3, 1};
    tbl[6]  = '{0, 1, 16'd50,   4'b0010, 4'b0000, 16'd50,   0, 1};
    tbl[7]  = '{0, 0, 16'd0,    4'b0010, 4'b0010, 16'd51,   1, 1};
    tbl[8]  = '{0, 1, 16'hFFFF, 4'b0000, 4'b0000, 16'hFFFF, 0, 1};
    tbl[9]  = '{0, 0, 16'd0,    4'b0100, 4'b0100, 16'h0000, 1, 1};
    tbl[10] = '{0, 0, 16'd0,    4'b0100, 4'b0100, 16'h0001, 2, 1};
    tbl[11] = '{0, 0, 16'd0,    4'b0000, 4'b0000, 16'h0001, 2, 1};
    tbl[12] = '{1, 0, 16'd0,    4'b0100, 4'b0100, 16'd0,    0, 0};
    tbl[13] = '{0, 0, 16'd0,    4'b0100, 4'b0000, 16'd0,    0, 0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].r; set_valid = tbl[i].s;
      set_value = tbl[i].v; req_valid = tbl[i].rv;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      @(negedge clk);
      cyc(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].rv);
      chk($sformatf("vec%0d_gc", i), 32'(gc), 32'(tbl[i].e_gc));
      chk($sformatf("vec%0d_cnt", i), grant_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_run", i), 32'(running), 32'(tbl[i].e_run));
    end

    // All four requesting: RR rotates 0..3, fixed priority always picks 0.
    cyc(0, 1, 16'd0, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      chk("seq_value", 32'(gc), 32'(k));
      cyc(0, 0, 16'd0, 4'b1111);
`ifdef GC_ARB_RR_EN
      chk("seq_idx", 32'(grant_idx), 32'(k % N));
`else
      chk("seq_idx", 32'(grant_idx), 32'd0);
`endif
    end
    chk("seq_gc_end", 32'(gc), 32'd8);
    chk("seq_cnt_end", grant_count, 32'd8);

    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 64) == 0, ($urandom % 16) == 0,
          W'($urandom), N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
